// File: rtl/but_multiplier_seq_if.sv
// Valid/ready operand and product streams for the sequential Booth multiplier.
// BOOTH_UNSIGNED_EN adds the in_signed operand-mode bit.
interface but_multiplier_seq_if #(
  parameter int M_SIZE   = 4,
  parameter int R_SIZE   = 4,
  parameter int RES_SIZE = M_SIZE + R_SIZE
);
  logic                in_valid;
  logic                in_ready;
  logic [M_SIZE-1:0]   in_m;
  logic [R_SIZE-1:0]   in_r;
`ifdef BOOTH_UNSIGNED_EN
  logic                in_signed;
`endif
  logic                out_valid;
  logic                out_ready;
  logic [RES_SIZE-1:0] out_res;

  modport slave (
`ifdef BOOTH_UNSIGNED_EN
    input  in_signed,
`endif
    input  in_valid, in_m, in_r, out_ready,
    output in_ready, out_valid, out_res
  );

  modport master (
`ifdef BOOTH_UNSIGNED_EN
    output in_signed,
`endif
    output in_valid, in_m, in_r, out_ready,
    input  in_ready, out_valid, out_res
  );
endinterface

// File: rtl/but_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one recode/add/shift step per clock.
// BOOTH_UNSIGNED_EN adds signed/unsigned operand selection (one extra step).
module but_multiplier_seq #(
  parameter int M_SIZE   = 4,
  parameter int R_SIZE   = 4,
  parameter int RES_SIZE = M_SIZE + R_SIZE
) (
  input logic               clk,
  input logic               rst,
  but_multiplier_seq_if.slave bus
);
`ifdef BOOTH_UNSIGNED_EN
  localparam int RXW = R_SIZE + 1;
`else
  localparam int RXW = R_SIZE;
`endif
  localparam int MXW = M_SIZE + 1;
  localparam int PW  = MXW + RXW + 1;
  localparam int N   = RXW;
  localparam int CW  = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nx;
  logic                accept, last, drain;
  logic [CW-1:0]       cnt;
  logic [MXW-1:0]      a, s;
  logic [PW-1:0]       p;
  logic [PW-1:0]       addend;
  logic signed [PW-1:0] sum, p_next;
  logic [MXW-1:0]      mx;
  logic [RXW-1:0]      rx;
  logic                out_valid;
  logic [RES_SIZE-1:0] out_res;

  // Extra top bit of Mx keeps -Mx representable for the most negative input.
`ifdef BOOTH_UNSIGNED_EN
  assign mx = {bus.in_signed & bus.in_m[M_SIZE-1], bus.in_m};
  assign rx = {bus.in_signed & bus.in_r[R_SIZE-1], bus.in_r};
`else
  assign mx = {bus.in_m[M_SIZE-1], bus.in_m};
  assign rx = bus.in_r;
`endif

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = out_valid;
  assign bus.out_res   = out_res;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    drain    = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept   = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (cnt == CW'(N - 1)) begin
        last     = 1'b1;
        state_nx = DONE;
      end
      DONE: if (bus.out_ready) begin
        drain    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Booth recode on the two LSBs, add into the upper field, arithmetic shift.
  always_comb begin
    case (p[1:0])
      2'b01:   addend = {a, {(RXW + 1){1'b0}}};
      2'b10:   addend = {s, {(RXW + 1){1'b0}}};
      default: addend = '0;
    endcase
    sum    = p + addend;
    p_next = sum >>> 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      cnt       <= '0;
      p         <= '0;
      a         <= '0;
      s         <= '0;
    end else begin
      if (accept) begin
        a   <= mx;
        s   <= -mx;
        p   <= {{MXW{1'b0}}, rx, 1'b0};
        cnt <= '0;
      end
      if (state == BUSY) begin
        p   <= p_next;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        out_res   <= p_next[RES_SIZE:1];
        out_valid <= 1'b1;
      end
      if (drain) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_but_multiplier_seq.sv
// Directed self-checking bench for but_multiplier_seq (default 4x4 widths).
module tb_but_multiplier_seq;
`ifdef BOOTH_UNSIGNED_EN
  localparam int N = 5;
`else
  localparam int N = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  but_multiplier_seq_if #(.M_SIZE(4), .R_SIZE(4)) bus ();
  but_multiplier_seq #(.M_SIZE(4), .R_SIZE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] r);
    logic signed [3:0] sm, sr;
    int prod;
    sm   = m;
    sr   = r;
    prod = int'(sm) * int'(sr);
    return prod[7:0];
  endfunction

  // Returns one cycle after the accept edge with in_valid dropped.
  task automatic accept(input logic [3:0] m, input logic [3:0] r);
    int w;
    bus.in_m     = m;
    bus.in_r     = r;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 50) begin tick(); w++; end
    if (w >= 50) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic op(input logic [3:0] m, input logic [3:0] r, input logic [7:0] exp,
                    input string tag);
    int lat;
    accept(m, r);
    lat = 1;
    tick();
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    chk({tag, "_lat"}, lat, N);
    chk(tag, {24'd0, bus.out_res}, {24'd0, exp});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int w, seen, prev_acc, acc;
    logic [3:0] m, r;
    logic [7:0] exp;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_m      = '0;
    bus.in_r      = '0;
    bus.out_ready = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
    bus.in_signed = 1'b1;
`endif
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_res", bus.out_res, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    op(4'd3, 4'd5, 8'h0F, "t1_3x5");
    op(4'h8, 4'h8, 8'h40, "t2_min_x_min");
    op(4'd7, 4'h8, 8'hC8, "t2_7x_m8");
    op(4'h0, 4'h8, 8'h00, "t2_0x_m8");
    op(4'hF, 4'h7, 8'hF9, "t2_m1x7");

    // Hold the result; operand changes after accept must not leak in.
    accept(4'hD, 4'd5);
    bus.in_m = 4'h1;
    bus.in_r = 4'h1;
    w = 0;
    while (!bus.out_valid && w < 40) begin tick(); w++; end
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", bus.out_valid, 1);
      chk("t3_hold_res", bus.out_res, 8'hF1);
      chk("t3_hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("t3_drain_in_ready", bus.in_ready, 1);
    chk("t3_drain_valid", bus.out_valid, 0);

    // Streaming with in_valid held high and the sink always ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 16; i++) begin
      m = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      bus.in_m = m;
      bus.in_r = r;
      exp = ref_mul(m, r);
      w = 0;
      while (!bus.in_ready && w < 50) begin tick(); w++; end
      tick();
      acc = cyc;
      bus.in_m = ~m;
      bus.in_r = ~r;
      if (i > 0) chk("t4_spacing", acc - prev_acc, N + 2);
      prev_acc = acc;
      w = 0;
      while (!bus.out_valid && w < 40) begin tick(); w++; end
      chk("t4_prod", {24'd0, bus.out_res}, {24'd0, exp});
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();

    // Reset mid-operation discards the in-flight product.
    accept(4'd6, 4'd7);
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_after_rst_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      if (bus.out_valid) seen = 1;
      tick();
    end
    chk("t5_no_valid", seen, 0);
    op(4'd2, 4'd2, 8'h04, "t5_2x2");

`ifdef BOOTH_UNSIGNED_EN
    bus.in_signed = 1'b0;
    op(4'hF, 4'hF, 8'hE1, "t6_unsigned_15x15");
    op(4'h8, 4'hF, 8'h78, "t6_unsigned_8x15");
    bus.in_signed = 1'b1;
    op(4'hF, 4'hF, 8'h01, "t6_signed_m1xm1");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
